// File: rtl/regfile_sb.sv
`default_nettype none
// ============================================================================
// Module      : regfile_sb
// Description : Register file with two combinational read ports, one writeback
//               port, a link write into the top register, and a per-register
//               pending scoreboard with a saturating-free population count.
//               Optional same-cycle read bypass: define REGFILE_BYPASS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_sb #(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          clrn,
  input  logic [AW-1:0] rna,
  input  logic [AW-1:0] rnb,
  output logic [DW-1:0] qa,
  output logic [DW-1:0] qb,
  output logic          busy_a,
  output logic          busy_b,
  input  logic          we,
  input  logic [AW-1:0] wn,
  input  logic [DW-1:0] d,
  input  logic          jal,
  input  logic [DW-1:0] dp4,
  input  logic          iss_en,
  input  logic [AW-1:0] iss_rn,
  output logic [AW:0]   npend
);

  localparam int            c_NREG = 2**AW;
  localparam logic [AW-1:0] c_LAST = '1;

  // r0 is not stored; reads of address 0 are forced to zero below
  logic [DW-1:0]     r_regs [1:c_NREG-1];
  logic [c_NREG-1:0] r_pend;
  logic [AW:0]       r_npend;

  logic [c_NREG-1:0] w_set;
  logic [c_NREG-1:0] w_clr;
  logic [c_NREG-1:0] w_pend_nxt;
  logic [AW:0]       w_cnt;

  // Storage: link write into the top register has priority over writeback
  generate
    for (genvar i = 1; i < c_NREG; i++) begin : g_reg
      localparam logic [AW-1:0] c_IDX = AW'(i);
      always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
          r_regs[i] <= '0;
        end else if (jal && (c_IDX == c_LAST)) begin
          r_regs[i] <= dp4;
        end else if (we && (wn == c_IDX)) begin
          r_regs[i] <= d;
        end
      end
    end
  endgenerate

  // Scoreboard set/clear requests for this edge; r0 is never touched
  always_comb begin
    w_set = '0;
    w_clr = '0;
    if (iss_en && (iss_rn != '0)) w_set[iss_rn] = 1'b1;
    if (we && (wn != '0))         w_clr[wn]     = 1'b1;
    if (jal)                      w_clr[c_LAST] = 1'b1;
  end

  // Set is applied after clear so a new issue wins a same-edge collision
  assign w_pend_nxt = (r_pend & ~w_clr) | w_set;

  // Population count of the next pending vector, registered with the bits
  always_comb begin
    w_cnt = '0;
    for (int k = 1; k < c_NREG; k++) begin
      w_cnt = w_cnt + (AW+1)'(w_pend_nxt[k]);
    end
  end

  // Pending bits and their count update together
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_pend  <= '0;
      r_npend <= '0;
    end else begin
      r_pend  <= w_pend_nxt;
      r_npend <= w_cnt;
    end
  end

  assign npend = r_npend;

  // Read port A: zero for r0, optionally forwarding this cycle's writes
  always_comb begin
    qa     = '0;
    busy_a = 1'b0;
    if (rna != '0) begin
      qa     = r_regs[rna];
      busy_a = r_pend[rna];
`ifdef REGFILE_BYPASS_EN
      if (jal && (rna == c_LAST)) begin
        qa = dp4;
      end else if (we && (wn == rna)) begin
        qa = d;
      end
      if (w_clr[rna]) busy_a = w_set[rna];
`endif
    end
  end

  // Read port B: identical behaviour to port A
  always_comb begin
    qb     = '0;
    busy_b = 1'b0;
    if (rnb != '0) begin
      qb     = r_regs[rnb];
      busy_b = r_pend[rnb];
`ifdef REGFILE_BYPASS_EN
      if (jal && (rnb == c_LAST)) begin
        qb = dp4;
      end else if (we && (wn == rnb)) begin
        qb = d;
      end
      if (w_clr[rnb]) busy_b = w_set[rnb];
`endif
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_regfile_sb.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_sb
// Description : Directed self-checking bench for regfile_sb (DW=32, AW=5).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_sb;

  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk;
  logic          clrn;
  logic [AW-1:0] rna, rnb;
  logic [DW-1:0] qa, qb;
  logic          busy_a, busy_b;
  logic          we;
  logic [AW-1:0] wn;
  logic [DW-1:0] d;
  logic          jal;
  logic [DW-1:0] dp4;
  logic          iss_en;
  logic [AW-1:0] iss_rn;
  logic [AW:0]   npend;

  int checks = 0;
  int errors = 0;

  regfile_sb #(.DW(DW), .AW(AW)) u_dut (
    .clk    (clk),
    .clrn   (clrn),
    .rna    (rna),
    .rnb    (rnb),
    .qa     (qa),
    .qb     (qb),
    .busy_a (busy_a),
    .busy_b (busy_b),
    .we     (we),
    .wn     (wn),
    .d      (d),
    .jal    (jal),
    .dp4    (dp4),
    .iss_en (iss_en),
    .iss_rn (iss_rn),
    .npend  (npend)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge; inputs change and outputs are sampled 1ns after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we = 1'b0; wn = '0; d = '0; jal = 1'b0; dp4 = '0; iss_en = 1'b0; iss_rn = '0;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] v);
    we = 1'b1; wn = a; d = v;
    tick();
    idle();
  endtask

  task automatic issue(input logic [AW-1:0] a);
    iss_en = 1'b1; iss_rn = a;
    tick();
    idle();
  endtask

  initial begin
    clrn = 1'b0;
    rna = '0; rnb = '0;
    idle();
    #1;
    chk("rst_qa", 64'(qa), 64'h0);
    chk("rst_busy_a", 64'(busy_a), 64'h0);
    chk("rst_npend", 64'(npend), 64'h0);

    // Reset release, then write r5 and issue r7 on the same edge
    @(negedge clk); clrn = 1'b1;
    tick();
    we = 1'b1; wn = 5'd5; d = 32'h1234; iss_en = 1'b1; iss_rn = 5'd7;
    tick();
    idle();
    rna = 5'd5; rnb = 5'd7;
    #1;
    chk("pre_rst_qa_r5", 64'(qa), 64'h1234);
    chk("pre_rst_busy_r7", 64'(busy_b), 64'h1);
    chk("pre_rst_npend", 64'(npend), 64'h1);
    // Asynchronous reset mid-cycle
    @(negedge clk); clrn = 1'b0;
    #1;
    chk("async_rst_qa_r5", 64'(qa), 64'h0);
    chk("async_rst_busy_r7", 64'(busy_b), 64'h0);
    chk("async_rst_npend", 64'(npend), 64'h0);
    // Writes while held in reset are ignored
    we = 1'b1; wn = 5'd5; d = 32'hABCD;
    tick();
    idle();
    chk("rst_hold_no_write", 64'(qa), 64'h0);
    @(negedge clk); clrn = 1'b1;
    tick();

    // Write/read and r0 discard
    wr(5'd3, 32'hDEADBEEF);
    rna = 5'd3; #1;
    chk("wr_r3", 64'(qa), 64'hDEADBEEF);
    wr(5'd0, 32'hFFFF);
    rna = 5'd0; #1;
    chk("wr_r0_zero", 64'(qa), 64'h0);

    // Link collision: link wins on r31
    jal = 1'b1; dp4 = 32'h40; we = 1'b1; wn = 5'd31; d = 32'h99;
    tick(); idle();
    rna = 5'd31; #1;
    chk("link_wins_r31", 64'(qa), 64'h40);
    jal = 1'b1; dp4 = 32'h44; we = 1'b1; wn = 5'd4; d = 32'h99;
    tick(); idle();
    rna = 5'd4; rnb = 5'd31; #1;
    chk("both_r4", 64'(qa), 64'h99);
    chk("both_r31", 64'(qb), 64'h44);

    // Scoreboard
    issue(5'd2); issue(5'd9); issue(5'd2);
    rna = 5'd2; rnb = 5'd9; #1;
    chk("sb_npend2", 64'(npend), 64'h2);
    chk("sb_busy_r2", 64'(busy_a), 64'h1);
    wr(5'd2, 32'h7);
    chk("sb_wb_npend1", 64'(npend), 64'h1);
    chk("sb_wb_busy_r2", 64'(busy_a), 64'h0);
    we = 1'b1; wn = 5'd9; d = 32'h8; iss_en = 1'b1; iss_rn = 5'd9;
    tick(); idle();
    chk("sb_same_edge_busy_r9", 64'(busy_b), 64'h1);
    chk("sb_same_edge_npend", 64'(npend), 64'h1);
    issue(5'd31);
    rna = 5'd31; #1;
    chk("sb_r31_pend", 64'(busy_a), 64'h1);
    chk("sb_npend_r31", 64'(npend), 64'h2);
    jal = 1'b1; dp4 = 32'h100;
    tick(); idle();
    chk("sb_jal_clears", 64'(busy_a), 64'h0);
    chk("sb_jal_npend", 64'(npend), 64'h1);

    // Same-cycle read of a register being written
    wr(5'd6, 32'h11);
    issue(5'd6);
    rna = 5'd6;
    we = 1'b1; wn = 5'd6; d = 32'h55;
    #1;
`ifdef REGFILE_BYPASS_EN
    chk("byp_qa", 64'(qa), 64'h55);
    chk("byp_busy_a", 64'(busy_a), 64'h0);
`else
    chk("nobyp_qa", 64'(qa), 64'h11);
    chk("nobyp_busy_a", 64'(busy_a), 64'h1);
`endif
    tick(); idle();
    chk("post_wr_qa", 64'(qa), 64'h55);
    chk("post_wr_busy_a", 64'(busy_a), 64'h0);

    // Saturation from a clean state
    @(negedge clk); clrn = 1'b0;
    @(negedge clk); clrn = 1'b1;
    for (int i = 1; i < 32; i++) issue(AW'(i));
    chk("sat_npend31", 64'(npend), 64'd31);
    issue(5'd17); issue(5'd31);
    chk("sat_extra_npend", 64'(npend), 64'd31);
    issue(5'd0);
    rna = 5'd0; rnb = 5'd17; #1;
    chk("sat_r0_npend", 64'(npend), 64'd31);
    chk("sat_r0_busy", 64'(busy_a), 64'h0);
    chk("sat_r17_busy", 64'(busy_b), 64'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 SHALL have parameter DW, default 32, data width in bits.
REQ-002 SHALL have parameter AW, default 5, register address width; NREG = 2**AW registers, r0 hardwired zero.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port clrn  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports rna, rnb  input  AW  read addresses, ports A and B.
REQ-006 SHALL have ports qa, qb  output  DW  read data, combinational.
REQ-007 SHALL have ports busy_a, busy_b  output  1  addressed register has a pending write.
REQ-008 SHALL have ports we, wn, d  input  1/AW/DW  writeback enable, address, data.
REQ-009 SHALL have ports jal, dp4  input  1/DW  link write of dp4 into r(NREG-1).
REQ-010 SHALL have ports iss_en, iss_rn  input  1/AW  issue: mark destination pending.
REQ-011 SHALL have port npend  output  AW+1  count of currently pending registers.

Function
REQ-012 SHALL return 0 on qa/qb and 0 on busy_a/busy_b whenever the read address is 0.
REQ-013 SHALL write d into r[wn] at the rising edge when we=1 and wn!=0; wn=0 writes are discarded.
REQ-014 SHALL write dp4 into r[NREG-1] at the rising edge when jal=1, independent of we.
REQ-015 SHALL, when jal=1 and we=1 with wn=NREG-1 in the same cycle, store dp4 (link wins); other wn values receive both writes.
REQ-016 SHALL hold one pending bit per register r1..r(NREG-1); r0 never pending.
REQ-017 SHALL set pending[iss_rn] at the rising edge when iss_en=1 and iss_rn!=0.
REQ-018 SHALL clear pending[wn] at the rising edge when we=1 and wn!=0, and clear pending[NREG-1] when jal=1.
REQ-019 SHALL, on same-edge set and clear of the same register, leave it pending (new issue wins).
REQ-020 SHALL drive busy_a = pending[rna], busy_b = pending[rnb] (subject to REQ-025).
REQ-021 SHALL keep npend equal to the population count of pending bits, updated in the same edge as the bits; never exceeds NREG-1, never wraps.
REQ-022 SHALL accept iss_en on an already-pending register without changing npend.
REQ-023 SHALL make a written value visible on qa/qb in the cycle after the write edge (without bypass).

Reset
REQ-024 SHALL, while clrn=0, asynchronously clear all registers and pending bits; qa=qb=0, busy_a=busy_b=0, npend=0; writes and issues ignored until clrn=1 at an edge.

Configuration
REQ-025 SHALL, with macro REGFILE_BYPASS_EN defined, forward same-cycle writes: qa=d when we=1, wn=rna!=0 (dp4 if jal=1 and rna=NREG-1, link priority per REQ-015), busy_a=0 for a register being cleared that cycle unless iss_en targets it; same for port B.
REQ-026 SHALL, without REGFILE_BYPASS_EN, read register contents and pending bits only; no forwarding logic present.

Verification
REQ-027 Reset: write r5=0x1234, issue r7, pulse clrn=0 mid-cycle -> qa(r5)=0, busy(r7)=0, npend=0 immediately.
REQ-028 Write/read: we=1, wn=3, d=0xDEADBEEF; next cycle rna=3 -> qa=0xDEADBEEF; wn=0, d=0xFFFF -> qa(r0)=0.
REQ-029 Link collision: jal=1, dp4=0x40, we=1, wn=31, d=0x99 -> r31=0x40; repeat with wn=4 -> r4=0x99, r31=0x40.
REQ-030 Scoreboard: issue r2, r9, r2 again -> npend=2, busy(r2)=1; we to r2 -> npend=1; same-edge issue+we to r9 -> busy(r9)=1, npend=1.
REQ-031 Bypass (REGFILE_BYPASS_EN): rna=6, we=1, wn=6, d=0x55 in same cycle -> qa=0x55, busy_a=0; without macro -> qa=old r6, busy_a=pending value.
REQ-032 Saturation: issue all r1..r31 -> npend=31; extra issues -> npend stays 31; issue r0 -> ignored.
